// File: rtl/axis_xfft_quant_pkg.sv
// Shared constants, state type and helpers for the 16-lane FFT output quantiser.
package axis_xfft_quant_pkg;

  localparam int N         = 16;
  localparam int BIN       = 32;
  localparam int BOUT      = 16;
  localparam int NPTS_LOG2 = 15;
  localparam int SHIFT_MAX = 16;
  localparam int USER_W    = 16;

  // Lane slicing: component c (I = 2*lane, Q = 2*lane+1) sits at [c*W +: W].
  localparam int NCOMP  = 2 * N;
  localparam int IN_W   = NCOMP * BIN;
  localparam int OUT_W  = NCOMP * BOUT;
  localparam int FIFO_W = OUT_W + USER_W + 1;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [4:0] clamp_shift(input logic [4:0] s);
    return (s > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : s;
  endfunction

endpackage

// File: rtl/fft_quant_lane.sv
// One I or Q component: round half up, arithmetic right shift, saturate to BOUT bits (registered).
module fft_quant_lane
  import axis_xfft_quant_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [BIN-1:0]  din,
  input  logic [4:0]      shift,
  output logic [BOUT-1:0] dout,
  output logic            sat
);

  localparam logic signed [BIN:0] SAT_HI = (BIN+1)'((2 ** (BOUT - 1)) - 1);
  localparam logic signed [BIN:0] SAT_LO = ~SAT_HI;

  logic signed [BIN:0] v_ext;
  logic signed [BIN:0] half;
  logic signed [BIN:0] r;
  logic [BOUT-1:0]     q;
  logic                q_sat;

  // One extra bit of headroom keeps v + 2^(s-1) from wrapping at the top of the range.
  always_comb begin
    v_ext = {din[BIN-1], din};
    half  = '0;
    if (shift != 5'd0) half = (BIN+1)'(1) << (shift - 5'd1);
    r     = (v_ext + half) >>> shift;
    q     = r[BOUT-1:0];
    q_sat = 1'b0;
    if (r > SAT_HI) begin
      q     = SAT_HI[BOUT-1:0];
      q_sat = 1'b1;
    end else if (r < SAT_LO) begin
      q     = SAT_LO[BOUT-1:0];
      q_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      sat  <= 1'b0;
    end else begin
      dout <= q;
      sat  <= q_sat;
    end
  end

endmodule

// File: rtl/axis_xfft_16x32768_quant.sv
// Frame-checking quantiser for the 16-lane 32768-point FFT stream, re-emitted as AXI-Stream with backpressure.
// Optional saturation counter: define AXIS_XFFT_QUANT_SAT_CNT_EN.
//
// Output handshake: m_axis_tvalid rises independently of m_axis_tready; once high, tvalid and
// tdata/tuser/tlast hold until a cycle with tvalid & tready, which is the transfer.
module axis_xfft_16x32768_quant
  import axis_xfft_quant_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [IN_W-1:0]     s_axis_tdata,
  input  logic [USER_W-1:0]   s_axis_tuser,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  input  logic [4:0]          shift,
  input  logic                clr_err,
  output logic [OUT_W-1:0]    m_axis_tdata,
  output logic [USER_W-1:0]   m_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                frame_err,
  output logic                ovf,
  output logic [31:0]         sat_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t               state_q, state_d;
  logic [NPTS_LOG2-1:0] exp_idx_q;
  logic [4:0]           shift_q;
  logic                 idx_match, last_match, good, mism, ovf_evt;

  assign idx_match  = s_axis_tuser[NPTS_LOG2-1:0] == exp_idx_q;
  assign last_match = s_axis_tlast == (&exp_idx_q);
  assign good       = (state_q == RUN) && s_axis_tvalid && idx_match && last_match;
  assign mism       = (state_q == RUN) && s_axis_tvalid && !(idx_match && last_match);

  // An overflow always forces resynchronisation, even over a tlast seen in SYNC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC: if (s_axis_tvalid && s_axis_tlast) state_d = RUN;
      RUN:  if (mism) state_d = SYNC;
    endcase
    if (ovf_evt) state_d = SYNC;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= SYNC;
      exp_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SYNC && s_axis_tvalid && s_axis_tlast) exp_idx_q <= '0;
      else if (good) exp_idx_q <= exp_idx_q + NPTS_LOG2'(1);
      if (good && exp_idx_q == '0) shift_q <= clamp_shift(shift);
    end
  end

  // Stage 1: register accepted beats.
  logic              s1_valid, s1_last;
  logic [IN_W-1:0]   s1_data;
  logic [USER_W-1:0] s1_user;

  always_ff @(posedge aclk) begin
    if (areset) s1_valid <= 1'b0;
    else        s1_valid <= good;
    s1_data <= s_axis_tdata;
    s1_user <= s_axis_tuser;
    s1_last <= s_axis_tlast;
  end

  // Stage 2: quantise every component.
  logic              s2_valid, s2_last;
  logic [OUT_W-1:0]  s2_data;
  logic [USER_W-1:0] s2_user;
  logic [NCOMP-1:0]  lane_sat;

  for (genvar c = 0; c < NCOMP; c++) begin : g_lane
    fft_quant_lane u_lane (
      .clk   (aclk),
      .rst   (areset),
      .din   (s1_data[c*BIN +: BIN]),
      .shift (shift_q),
      .dout  (s2_data[c*BOUT +: BOUT]),
      .sat   (lane_sat[c])
    );
  end

  always_ff @(posedge aclk) begin
    if (areset) s2_valid <= 1'b0;
    else        s2_valid <= s1_valid;
    s2_user <= s1_user;
    s2_last <= s1_last;
  end

  // First-word-fall-through FIFO; a write while full is allowed only alongside a read.
  logic [FIFO_W-1:0] mem [DEPTH];
  logic [FIFO_W-1:0] head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, empty, rd_en, wr_en;

  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign rd_en   = m_axis_tvalid && m_axis_tready;
  assign wr_en   = s2_valid && (!full || rd_en);
  assign ovf_evt = s2_valid && full && !rd_en;

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= {s2_last, s2_user, s2_data};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_axis_tvalid = !empty;
  assign head          = empty ? '0 : mem[rd_ptr];
  assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = head;

  // Sticky flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (mism)         frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovf_evt)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
    end
  end

`ifdef AXIS_XFFT_QUANT_SAT_CNT_EN
  logic s2_sat;
  assign s2_sat = |lane_sat;

  always_ff @(posedge aclk) begin
    if (areset || clr_err)                  sat_cnt <= '0;
    else if (wr_en && s2_sat && ~&sat_cnt)  sat_cnt <= sat_cnt + 32'd1;
  end
`else
  logic sat_unused;
  assign sat_unused = |lane_sat;
  assign sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_axis_xfft_16x32768_quant.sv
// Scoreboard bench for axis_xfft_16x32768_quant: random lane data, behavioural frame/quantise model.
`timescale 1ns/1ps
module tb_axis_xfft_16x32768_quant;

  localparam int NC   = 32;
  localparam int IW   = NC * 32;
  localparam int OW   = NC * 16;
  localparam int UW   = 16;
  localparam int FW   = OW + UW + 1;
  localparam int NPTS = 32768;

  // Clock / reset
  logic          aclk = 1'b0;
  logic          areset;
  logic [IW-1:0] s_axis_tdata;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic [4:0]    shift;
  logic          clr_err;
  logic [OW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          frame_err;
  logic          ovf;
  logic [31:0]   sat_cnt;

  always #5 aclk = ~aclk;

  axis_xfft_16x32768_quant dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .shift         (shift),
    .clr_err       (clr_err),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_err     (frame_err),
    .ovf           (ovf),
    .sat_cnt       (sat_cnt)
  );

  // Scoreboard state and reference model
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [FW-1:0] exp_q[$];
  bit            m_run = 1'b0;
  int            m_idx = 0;
  int            m_shift = 0;
  longint        m_sat = 0;
  bit            m_ferr = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_last_sat = 1'b0;
  logic [FW-1:0] last_word = '0;
  logic [FW-1:0] tlast_word = '0;
  bit            stall_prev = 1'b0;
  logic [FW-1:0] stall_word = '0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint quant(input longint v, input int s, output bit sat);
    longint r;
    r = (s == 0) ? v : ((v + (longint'(1) << (s - 1))) >>> s);
    sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      sat = 1'b1;
    end
    return r;
  endfunction

  function automatic void model_beat(input logic [UW-1:0] user, input bit last,
                                     input logic [IW-1:0] d, input int sh);
    logic [OW-1:0]      out;
    logic signed [31:0] comp;
    longint             r;
    bit                 s, any_sat;
    if (!m_run) begin
      if (last) begin
        m_run = 1'b1;
        m_idx = 0;
      end
      return;
    end
    if (int'(user[14:0]) != m_idx || last != (m_idx == NPTS - 1)) begin
      m_ferr = 1'b1;
      m_run  = 1'b0;
      return;
    end
    if (m_idx == 0) m_shift = (sh > 16) ? 16 : sh;
    any_sat = 1'b0;
    for (int c = 0; c < NC; c++) begin
      comp = d[c*32 +: 32];
      r = quant(longint'(comp), m_shift, s);
      out[c*16 +: 16] = r[15:0];
      any_sat |= s;
    end
    exp_q.push_back({last, user, out});
    m_last_sat = any_sat;
    if (any_sat && m_sat < 64'hFFFF_FFFF) m_sat++;
    m_idx = (m_idx + 1) % NPTS;
  endfunction

  // Monitor: pops on every transfer, and checks the output holds while stalled.
  always @(negedge aclk) begin
    logic [FW-1:0] got;
    got = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    if (areset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", FW'(m_axis_tvalid), FW'(1));
        check("stall_word", got, stall_word);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", got);
        end else begin
          check("out_beat", got, exp_q.pop_front());
        end
        last_word = got;
        if (m_axis_tlast) tlast_word = got;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_word = got;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int idx, input bit last);
    logic [IW-1:0] d;
    for (int c = 0; c < NC; c++) d[c*32 +: 32] = 32'(int'($urandom) >>> $urandom_range(0, 24));
    d[0   +: 32] = 32'd1234;
    d[64  +: 32] = 32'd24;
    d[96  +: 32] = -32'sd24;
    d[128 +: 32] = 32'd40000;
    d[160 +: 32] = -32'sd40000;
    s_axis_tdata  = d;
    s_axis_tuser  = UW'(idx);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    if (!areset) model_beat(UW'(idx), last, d, int'(shift));
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_bp(input int idx);
    m_axis_tready = 1'($urandom_range(0, 1));
    send(idx, 1'b0);
    m_axis_tready = 1'b1;
    idle(1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    idle(2);
  endtask

  task automatic check_sat(input string name);
`ifdef AXIS_XFFT_QUANT_SAT_CNT_EN
    check(name, FW'(sat_cnt), FW'(32'(m_sat)));
`else
    check(name, FW'(sat_cnt), '0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, FW'(m_axis_tvalid), '0);
    check({tag, "_word"}, {m_axis_tlast, m_axis_tuser, m_axis_tdata}, '0);
    check({tag, "_frame_err"}, FW'(frame_err), '0);
    check({tag, "_ovf"}, FW'(ovf), '0);
    check({tag, "_sat_cnt"}, FW'(sat_cnt), '0);
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    shift         = 5'd0;
    clr_err       = 1'b0;
    m_axis_tready = 1'b1;
    idle(3);
    areset = 1'b0;
    check_idle_outputs("reset");

    // Unsynchronised beats are dropped; the tlast beat arms the next frame.
    for (int i = 0; i < 100; i++) send(i, 1'b0);
    send(NPTS - 1, 1'b1);
    idle(4);
    check("sync_drop_valid", FW'(m_axis_tvalid), '0);

    // First beat latency, then a full frame with a mid-frame shift change.
    send(0, 1'b0);
    idle(1);
    check("lat_cycle2", FW'(m_axis_tvalid), '0);
    idle(1);
    check("lat_cycle3", FW'(m_axis_tvalid), FW'(1));
    for (int i = 1; i < NPTS; i++) begin
      if (i == NPTS / 2) shift = 5'd8;
      send(i, i == NPTS - 1);
    end
    for (int i = 0; i < 64; i++) send(i, 1'b0);
    wait_drain();
    check("tlast_tuser", FW'(tlast_word[FW-2 -: 16]), FW'(NPTS - 1));
    check("f2_lane0_i", FW'(tlast_word[0  +: 16]), FW'(16'h04D2));
    check("f2_sat_hi", FW'(tlast_word[64 +: 16]), FW'(16'h7FFF));
    check("f2_sat_lo", FW'(tlast_word[80 +: 16]), FW'(16'h8000));
    check("f3_lane0_i", FW'(last_word[0  +: 16]), FW'(16'h0005));
    check("f3_lane1_i", FW'(last_word[32 +: 16]), FW'(16'h0000));
    check("f3_lane2_i", FW'(last_word[64 +: 16]), FW'(16'h009C));
    check("frame_err_clean", FW'(frame_err), '0);

    // Index skip: 102 after 100 breaks the frame until the next tlast.
    for (int i = 64; i <= 100; i++) send(i, 1'b0);
    send(102, 1'b0);
    check("frame_err_set", FW'(frame_err), FW'(1));
    for (int i = 103; i <= 110; i++) send(i, 1'b0);
    send(111, 1'b1);
    pulse_clr();
    m_ferr = 1'b0;
    check("frame_err_clr", FW'(frame_err), '0);
    shift = 5'd4;
    for (int i = 0; i <= 40; i++) send(i, 1'b0);
    wait_drain();
    check("rnd_pos", FW'(last_word[32 +: 16]), FW'(16'h0002));
    check("rnd_neg", FW'(last_word[48 +: 16]), FW'(16'hFFFF));
    check("rnd_big_pos", FW'(last_word[64 +: 16]), FW'(16'h09C4));
    check("rnd_big_neg", FW'(last_word[80 +: 16]), FW'(16'hF63C));
    check_sat("sat_cnt_mid");

    // Stall for 10 cycles: four beats fit, the fifth overflows.
    m_axis_tready = 1'b0;
    for (int i = 41; i <= 45; i++) send(i, 1'b0);
    idle(5);
    void'(exp_q.pop_back());
    if (m_last_sat) m_sat--;
    m_run = 1'b0;
    m_ovf = 1'b1;
    check("ovf_set", FW'(ovf), FW'(m_ovf));
    check("ovf_fifo_valid", FW'(m_axis_tvalid), FW'(1));
    m_axis_tready = 1'b1;
    wait_drain();
    for (int i = 46; i <= 50; i++) send(i, 1'b0);
    send(51, 1'b1);
    pulse_clr();
    m_ovf = 1'b0;
    check("ovf_clr", FW'(ovf), '0);

    // Random backpressure with a rate the FIFO can always absorb.
    for (int i = 0; i <= 40; i++) send_bp(i);
    wait_drain();
    check_sat("sat_cnt_bp");

    // Mid-frame reset at index 500.
    for (int i = 41; i < 500; i++) send(i, 1'b0);
    areset = 1'b1;
    send(500, 1'b0);
    areset = 1'b0;
    exp_q.delete();
    m_run  = 1'b0;
    m_idx  = 0;
    m_sat  = 0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    check_idle_outputs("mid_reset");
    for (int i = 501; i <= 505; i++) send(i, 1'b0);
    idle(4);
    check("post_reset_drop", FW'(m_axis_tvalid), '0);
    send(506, 1'b1);
    for (int i = 0; i <= 30; i++) send(i, 1'b0);
    wait_drain();
    check_sat("sat_cnt_end");
    check("end_frame_err", FW'(frame_err), FW'(m_ferr));
    check("end_ovf", FW'(ovf), FW'(m_ovf));
    check("end_tvalid", FW'(m_axis_tvalid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
